// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic START_BIT          = 1'b0;
  localparam int   DEFAULT_DATA_WIDTH = 8;
  localparam int   MIN_PRESCALE       = 5;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// rtl/uart_rx_data_sampler.sv - three mid-bit sample flops and majority vote
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic       RX_IN,
  input  logic [4:0] Prescale,
  input  logic [4:0] edge_count,
  input  logic       enable,
  output logic       sampled
);

  logic [4:0] mid;
  logic [2:0] samples;

  assign mid = Prescale >> 1;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      samples <= 3'b111;
    end else if (enable) begin
      if (edge_count == mid - 5'd1) samples[0] <= RX_IN;
      if (edge_count == mid)        samples[1] <= RX_IN;
      if (edge_count == mid + 5'd1) samples[2] <= RX_IN;
    end
  end

  assign sampled = majority3(samples);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FSM, deserializer and frame checks; parity via UART_RX_PARITY_EN
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [4:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [3:0]            bit_count,
  input  logic [4:0]            edge_count,
  output logic                  count_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e             state, state_nxt;
  logic                  sampled;
  logic                  last_edge;
  logic                  start_seen;
  logic [DATA_WIDTH-1:0] shadow;
  logic                  par_err_q;

  assign last_edge  = (edge_count == Prescale);
  assign start_seen = (state == ST_IDLE) && (RX_IN == START_BIT);
  assign count_EN   = (state != ST_IDLE);
  assign par_err    = par_err_q;

  uart_rx_data_sampler u_sampler (
    .CLK        (CLK),
    .Reset      (Reset),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .edge_count (edge_count),
    .enable     (count_EN),
    .sampled    (sampled)
  );

`ifdef UART_RX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;

  // Frame format is frozen at start detection so a mid-frame change cannot skew the bit count.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err_q <= 1'b0;
    end else if (start_seen) begin
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      par_err_q <= 1'b0;
    end else if (state == ST_PARITY && last_edge) begin
      par_err_q <= (sampled != ((^shadow) ^ par_typ_q));
    end
  end
`else
  logic unused_par_cfg;
  assign unused_par_cfg = ^{PAR_EN, PAR_TYP};
  assign par_err_q      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (RX_IN == START_BIT) state_nxt = ST_START;
      end
      ST_START: begin
        if (last_edge) state_nxt = sampled ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (last_edge && bit_count == LAST_DATA_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (last_edge) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (last_edge) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // P_DATA only moves on a clean frame; the shadow absorbs everything else.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      shadow     <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_seen) begin
        stp_err <= 1'b0;
      end
      if (state == ST_DATA && last_edge) begin
        shadow <= {sampled, shadow[DATA_WIDTH-1:1]};
      end
      if (state == ST_STOP && last_edge) begin
        stp_err <= ~sampled;
        if (sampled && !par_err_q) begin
          P_DATA     <= shadow;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with an edge-counter model
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  typedef struct {
    int         len;
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  logic          CLK   = 1'b0;
  logic          Reset = 1'b1;
  logic          RX_IN = 1'b1;
  logic [4:0]    Prescale = 5'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [3:0]    bit_count;
  logic [4:0]    edge_count;
  logic          count_EN;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_valid_pulses = 0;
  int         dv_cycles = 0;
  int         run_len = 0;
  logic       prev_en = 1'b0;
  logic [7:0] model_data = 8'h00;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .bit_count  (bit_count),
    .edge_count (edge_count),
    .count_EN   (count_EN),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  // Edge/bit counter that sits beside the controller in the real RX path.
  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (!count_EN) begin
      edge_count <= 5'd1;
      bit_count  <= 4'd0;
    end else if (edge_count == Prescale) begin
      edge_count <= 5'd1;
      bit_count  <= bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 5'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // A frame ends when count_EN falls; that is when its expected result is popped.
  always @(negedge CLK) begin
    if (!Reset) begin
      prev_en = 1'b0;
      run_len = 0;
    end else begin
      if (data_valid) dv_cycles++;
      if (prev_en && !count_EN) begin
        check_eq("pending_frame", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("frame_len",  run_len,    mon_e.len);
          check_eq("data_valid", data_valid, mon_e.valid);
          check_eq("P_DATA",     P_DATA,     mon_e.data);
          check_eq("par_err",    par_err,    mon_e.perr);
          check_eq("stp_err",    stp_err,    mon_e.serr);
        end
        run_len = 0;
      end
      if (count_EN) run_len++;
      prev_en = count_EN;
    end
  end

  task automatic send_frame(input int p, input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic stop_bit, input int idle_after);
    logic bits [0:10];
    int   nsent;
    int   n;
    logic par_eff;
    exp_t e;
    nsent = pen ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]  = pbit;
    bits[10] = 1'b1;
    bits[nsent-1] = stop_bit;
`ifdef UART_RX_PARITY_EN
    par_eff = pen;
`else
    par_eff = 1'b0;
`endif
    n = par_eff ? 11 : 10;
    e.len   = n * p;
    e.perr  = par_eff && (bits[9] != ((^d) ^ ptyp));
    e.serr  = !bits[n-1];
    e.valid = !e.perr && !e.serr;
    if (e.valid) begin
      model_data = d;
      exp_valid_pulses++;
    end
    e.data = model_data;
    exp_q.push_back(e);
    Prescale = 5'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int i = 0; i < nsent; i++) begin
      RX_IN = bits[i];
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = 1'b1;
    repeat (idle_after) @(posedge CLK);
    #1;
  endtask

  task automatic false_start(input int p);
    exp_t e;
    e.len = p; e.valid = 1'b0; e.data = model_data; e.perr = 1'b0; e.serr = 1'b0;
    exp_q.push_back(e);
    Prescale = 5'(p);
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (3 * p) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_count_EN"},   count_EN,   0);
    check_eq({tag, "_P_DATA"},     P_DATA,     0);
    check_eq({tag, "_data_valid"}, data_valid, 0);
    check_eq({tag, "_par_err"},    par_err,    0);
    check_eq({tag, "_stp_err"},    stp_err,    0);
  endtask

  initial begin
    #2 Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    Reset = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 10);
    false_start(8);
    send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 10);
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    send_frame(8, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 10);

    // Abort a frame 0x81 two data bits in, then receive it whole.
    Prescale = 5'd8;
    RX_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (8) @(posedge CLK);
    #1 RX_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #2 Reset = 1'b0;
    model_data = 8'h00;
    #1;
    check_reset_outputs("midrst");
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 10);

    send_frame(5, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge CLK);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("dv_cycles", dv_cycles, exp_valid_pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX path. It sequences the edge/bit counter through start, data, optional parity and stop bits, and majority-samples `RX_IN` at mid-bit. It deserializes the data LSB-first, checks the parity and stop bits, and pulses `data_valid` for each clean frame. It sits between the serial input pin and the system's parallel data consumer, and directly drives the counter's enable.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; legal range 5..8.
- `CLK` input 1: system/oversampling clock; rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line; idles high.
- `Prescale` input 5: oversampling ratio, ≥5. Must be stable while not IDLE.
- `PAR_EN` input 1: parity bit present. Sampled in IDLE only.
- `PAR_TYP` input 1: 0 = even, 1 = odd. Sampled in IDLE only.
- `bit_count` input 4: from the edge counter; current bit index.
- `edge_count` input 5: from the edge counter; 1..Prescale within the current bit.
- `count_EN` output 1: edge counter enable. While low, the counter holds bit 0 / edge 1.
- `P_DATA` output DATA_WIDTH: received data, held until the next valid frame.
- `data_valid` output 1: one-cycle pulse when a frame completes with no error.
- `par_err` output 1: parity mismatch on the last frame.
- `stp_err` output 1: stop bit sampled low on the last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Registered state; Moore `count_EN` = (state != IDLE).
- **Mid-bit sampling**
  - mid = Prescale>>1.
  - Capture `RX_IN` at edge_count = mid-1, mid and mid+1 into three flops.
  - sampled = majority of the three.
  - "Last edge" means edge_count == Prescale.
- **IDLE**
  - On RX_IN==0: latch PAR_EN/PAR_TYP, clear par_err/stp_err, go to START.
  - Otherwise stay.
- **START**, at last edge:
  - sampled==0: go to DATA.
  - sampled==1: false start (glitch); go to IDLE with no flags set.
- **DATA**, at last edge:
  - P_DATA shadow ← {sampled, shadow[DATA_WIDTH-1:1]}.
  - When bit_count == DATA_WIDTH: go to PARITY if the latched PAR_EN is set, else STOP.
- **PARITY**, at last edge:
  - expected = ^shadow (even) or ~^shadow (odd).
  - par_err ← (sampled != expected).
  - Go to STOP.
- **STOP**, at last edge:
  - stp_err ← ~sampled.
  - If neither error is set: copy shadow to P_DATA and pulse data_valid.
  - Go to IDLE.
- The shadow register is internal. P_DATA updates only on a valid frame.
- Error flags hold until the next START entry.
- Transitions out of a bit occur only at its last edge. The counter wraps concurrently, so bit_count stays consistent.

## Timing
- **Reset values:** state IDLE; count_EN 0; P_DATA 0; data_valid 0; par_err 0; stp_err 0; sample flops 1.
- **Asynchronous reset mid-frame:**
  - Immediate return to IDLE with all outputs at their reset values.
  - No data_valid for the partial frame.
- **Start detection:** RX_IN low in cycle t → state START and count_EN=1 in cycle t+1, with edge_count=1 in t+1.
- **Frame length:** N = 1 + DATA_WIDTH + PAR_EN + 1 bits. data_valid asserts in the cycle after the STOP last edge, which is N·Prescale cycles after START entry.
- **Back-to-back frames:**
  - The controller spends ≥1 cycle in IDLE between frames so the counter clears.
  - A start bit beginning on that cycle is detected one cycle late. This is tolerated, since sampling is mid-bit.
- **Error outputs:**
  - par_err valid from the cycle after the PARITY last edge.
  - stp_err valid from the cycle after the STOP last edge.
- **Error flags and data_valid:** on a frame with an error, data_valid stays low and the error flags are set together.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** PARITY state, parity check and the PAR_EN/PAR_TYP latches are compiled in, as described above.
- **Undefined:**
  - PARITY state and parity logic are removed.
  - PAR_EN and PAR_TYP are ignored; the ports remain.
  - par_err is tied 0.
  - DATA always transitions to STOP.

## Structure
- Package `uart_rx_pkg`:
  - state encoding enum.
  - START_BIT = 0.
  - default DATA_WIDTH = 8.
  - MIN_PRESCALE = 5.
- Sub-module `uart_rx_data_sampler`: three sample flops plus the majority vote. Inputs are CLK, Reset, RX_IN, Prescale, edge_count and enable; output is sampled.
- The top level contains the FSM, shadow shift register, parity/stop checks and output registers.

## Test plan
- Prescale=8, PAR_EN=0, frame 0xA5 → P_DATA=0xA5, one data_valid pulse 80 cycles after START entry, par_err=0, stp_err=0.
- Prescale=8, RX_IN low for 2 cycles only → samples at edges 3/4/5 read high → return to IDLE; data_valid, par_err and stp_err stay 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 1 → par_err=1, data_valid stays 0, P_DATA keeps its previous value.
- Prescale=8, 0x5A with stop bit 0 → stp_err=1, no data_valid. The next clean frame 0x11 clears stp_err at START and yields P_DATA=0x11 with data_valid.
- Prescale=5, two back-to-back frames 0xFF then 0x00 → two data_valid pulses with correct data.
- Reset asserted in the DATA state → all outputs at reset values; the following full frame 0x81 is received correctly.
